// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if
//   Bundles the IF stage's two handshakes: the instruction-memory
//   request/response channel and the IF/ID output register.
//   master : fetch stage side (drives requests and IF/ID contents)
//   slave  : environment side (memory + decode stage)
//   Signals:
//     imemReqValid/imemReqReady/imemReqAddr : fetch request handshake
//     imemRespValid/imemRespData            : one-cycle response, no backpressure
//     ifValid/ifPc/ifInstr                  : IF/ID register contents
//     idReady                               : decode consumes IF/ID this cycle
interface pc_fetch_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imemReqValid;
  logic                  imemReqReady;
  logic [ADDR_WIDTH-1:0] imemReqAddr;
  logic                  imemRespValid;
  logic [31:0]           imemRespData;
  logic                  ifValid;
  logic [ADDR_WIDTH-1:0] ifPc;
  logic [31:0]           ifInstr;
  logic                  idReady;

  modport master (
    output imemReqValid, imemReqAddr, ifValid, ifPc, ifInstr,
    input  imemReqReady, imemRespValid, imemRespData, idReady
  );

  modport slave (
    input  imemReqValid, imemReqAddr, ifValid, ifPc, ifInstr,
    output imemReqReady, imemRespValid, imemRespData, idReady
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   IF stage of the 5-stage RISC-V core. Holds the PC, applies the 2-bit
//   PC select from branch resolution, keeps at most one instruction-memory
//   request outstanding and presents {pc, instr} in the IF/ID register.
//   Any non-zero pcSel is a redirect: it wins over every other event in the
//   cycle, flushes IF/ID and discards any in-flight fetch.
//   Ports:
//     clk, rst_n    : clock (rising), async active-low reset
//     pcSel         : 00 seq, 01 branch/jal, 10 jalr, 11 trap
//     branchTarget  : target for 01
//     jalrTarget    : target for 10 (bit0 cleared)
//     bus           : pc_fetch_stage_if.master (imem + IF/ID handshakes)
//     misalignTrap  : only with PC_MISALIGN_TRAP_EN; 1-cycle pulse when a
//                     01/10 target is not word aligned (pc goes to TRAP_VECTOR)
//   Optional feature macro: PC_MISALIGN_TRAP_EN
module pc_fetch_stage #(
  parameter int                  ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'('h100)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            pcSel,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic [ADDR_WIDTH-1:0] jalrTarget,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                  misalignTrap,
`endif
  pc_fetch_stage_if.master      bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                state, nextState;
  logic [ADDR_WIDTH-1:0] pc, reqPc, holdPc;
  logic [31:0]           holdInstr;
  logic                  redirect, reqFire;
  logic [ADDR_WIDTH-1:0] rawTarget, target;
  logic                  loadResp, loadHold, captureHold;

  assign redirect = (pcSel != 2'b00);

  always_comb begin
    rawTarget = TRAP_VECTOR;
    case (pcSel)
      2'b01:   rawTarget = branchTarget;
      2'b10:   rawTarget = {jalrTarget[ADDR_WIDTH-1:1], 1'b0};
      default: rawTarget = TRAP_VECTOR;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  // Alignment is judged after the jalr bit0 clear, so only bit1 can trip jalr.
  assign misaligned = ((pcSel == 2'b01) || (pcSel == 2'b10)) && (rawTarget[1:0] != 2'b00);
  assign target     = misaligned ? TRAP_VECTOR : rawTarget;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalignTrap <= 1'b0;
    else        misalignTrap <= misaligned;
  end
`else
  assign target = rawTarget;
`endif

  // Gated by rst_n so no request is seen while the core is held in reset.
  assign bus.imemReqValid = rst_n && (state == S_REQ) && !redirect;
  assign bus.imemReqAddr  = pc;
  assign reqFire          = bus.imemReqValid && bus.imemReqReady;

  always_comb begin
    nextState   = state;
    loadResp    = 1'b0;
    loadHold    = 1'b0;
    captureHold = 1'b0;
    case (state)
      S_REQ: begin
        if (reqFire) nextState = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imemRespValid) begin
          if (redirect) begin
            nextState = S_REQ;  // response lands with the redirect: drop it now
          end else if (!bus.ifValid || bus.idReady) begin
            loadResp  = 1'b1;
            nextState = S_REQ;
          end else begin
            captureHold = 1'b1;
            nextState   = S_HOLD;
          end
        end else if (redirect) begin
          nextState = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect)         nextState = S_REQ;
        else if (bus.idReady) begin
          loadHold  = 1'b1;
          nextState = S_REQ;
        end
      end
      S_DROP: begin
        // The awaited response retires the outstanding request even if a
        // new redirect arrives with it; staying here would wait forever.
        if (bus.imemRespValid) nextState = S_REQ;
      end
      default: nextState = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      reqPc <= '0;
    end else begin
      state <= nextState;
      if (redirect) begin
        pc <= target;
      end else if (reqFire) begin
        reqPc <= pc;
        pc    <= pc + ADDR_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdPc    <= '0;
      holdInstr <= NOP;
    end else if (captureHold) begin
      holdPc    <= reqPc;
      holdInstr <= bus.imemRespData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ifValid <= 1'b0;
      bus.ifPc    <= '0;
      bus.ifInstr <= NOP;
    end else if (redirect) begin
      bus.ifValid <= 1'b0;
    end else if (loadResp) begin
      bus.ifValid <= 1'b1;
      bus.ifPc    <= reqPc;
      bus.ifInstr <= bus.imemRespData;
    end else if (loadHold) begin
      bus.ifValid <= 1'b1;
      bus.ifPc    <= holdPc;
      bus.ifInstr <= holdInstr;
    end else if (bus.ifValid && bus.idReady) begin
      bus.ifValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage
//   Directed bench for pc_fetch_stage. Inputs change at the falling edge,
//   outputs are sampled 1 time unit later. The memory model answers a
//   request `lat` cycles after acceptance with data 32'hA000_0000 | addr.
module tb_pc_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic [1:0]  pcSel;
  logic [31:0] branchTarget;
  logic [31:0] jalrTarget;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalignTrap;
`endif

  pc_fetch_stage_if #(.ADDR_WIDTH(32)) bus ();

  pc_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcSel        (pcSel),
    .branchTarget (branchTarget),
    .jalrTarget   (jalrTarget),
`ifdef PC_MISALIGN_TRAP_EN
    .misalignTrap (misalignTrap),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  bit          pending  = 0;
  int          pendCnt  = 0;
  logic [31:0] pendAddr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // End the current cycle: sample the handshake, cross the rising edge,
  // then drive the memory response for the new cycle.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = bus.imemReqValid && bus.imemReqReady;
    a = bus.imemReqAddr;
    @(posedge clk);
    @(negedge clk);
    bus.imemRespValid = 1'b0;
    if (!rst_n) begin
      pending = 0;
    end else begin
      if (f) begin
        pending  = 1;
        pendCnt  = lat;
        pendAddr = a;
      end
      if (pending) begin
        pendCnt--;
        if (pendCnt == 0) begin
          bus.imemRespValid = 1'b1;
          bus.imemRespData  = 32'hA000_0000 | pendAddr;
          pending           = 0;
        end
      end
    end
  endtask

  task automatic doReset();
    rst_n             = 1'b0;
    pcSel             = 2'b00;
    branchTarget      = '0;
    jalrTarget        = '0;
    bus.imemReqReady  = 1'b1;
    bus.imemRespValid = 1'b0;
    bus.imemRespData  = '0;
    bus.idReady       = 1'b1;
    lat               = 1;
    pending           = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    pcSel             = 2'b00;
    branchTarget      = '0;
    jalrTarget        = '0;
    bus.imemReqReady  = 1'b1;
    bus.imemRespValid = 1'b0;
    bus.imemRespData  = '0;
    bus.idReady       = 1'b1;
    @(negedge clk); #1;
    chk("rst reqValid", 32'(bus.imemReqValid), 0);
    chk("rst ifValid",  32'(bus.ifValid), 0);
    chk("rst ifPc",     bus.ifPc, 32'h0);
    chk("rst ifInstr",  bus.ifInstr, 32'h0000_0013);
`ifdef PC_MISALIGN_TRAP_EN
    chk("rst trap",     32'(misalignTrap), 0);
`endif

    // Streaming, 1-cycle memory, decode always ready
    doReset();
    #1; chk("s c0 reqValid", 32'(bus.imemReqValid), 1);
        chk("s c0 addr", bus.imemReqAddr, 32'h0);
    tick();
    #1; chk("s c1 reqValid", 32'(bus.imemReqValid), 0);
        chk("s c1 ifValid", 32'(bus.ifValid), 0);
    tick();
    #1; chk("s c2 ifValid", 32'(bus.ifValid), 1);
        chk("s c2 ifPc", bus.ifPc, 32'h0);
        chk("s c2 ifInstr", bus.ifInstr, 32'hA000_0000);
        chk("s c2 addr", bus.imemReqAddr, 32'h4);
    tick();
    #1; chk("s c3 ifValid", 32'(bus.ifValid), 0);
    tick();
    #1; chk("s c4 ifValid", 32'(bus.ifValid), 1);
        chk("s c4 ifPc", bus.ifPc, 32'h4);
        chk("s c4 ifInstr", bus.ifInstr, 32'hA000_0004);
        chk("s c4 addr", bus.imemReqAddr, 32'h8);
    tick();
    #1; tick();
    #1; chk("s c6 ifPc", bus.ifPc, 32'h8);
        chk("s c6 ifInstr", bus.ifInstr, 32'hA000_0008);
        chk("s c6 addr", bus.imemReqAddr, 32'hC);

    // Back-pressure into HOLD, then flush of a valid IF/ID entry
    doReset();
    #1; tick();
    #1; tick();
    #1; tick();
    bus.idReady = 1'b0;
    #1; tick();
    #1; chk("h c4 ifPc", bus.ifPc, 32'h4);
        chk("h c4 ifValid", 32'(bus.ifValid), 1);
    tick();
    #1; tick();
    #1; chk("h c6 reqValid", 32'(bus.imemReqValid), 0);
        chk("h c6 ifPc", bus.ifPc, 32'h4);
    tick();
    #1; chk("h c7 reqValid", 32'(bus.imemReqValid), 0);
        chk("h c7 ifPc", bus.ifPc, 32'h4);
    tick();
    bus.idReady = 1'b1;
    #1; chk("h c8 ifPc", bus.ifPc, 32'h4);
    tick();
    #1; chk("h c9 ifPc", bus.ifPc, 32'h8);
        chk("h c9 ifInstr", bus.ifInstr, 32'hA000_0008);
        chk("h c9 ifValid", 32'(bus.ifValid), 1);
        chk("h c9 addr", bus.imemReqAddr, 32'hC);
    bus.idReady  = 1'b0;
    pcSel        = 2'b01;
    branchTarget = 32'h400;
    #1; chk("f c9 reqValid", 32'(bus.imemReqValid), 0);
    tick();
    pcSel = 2'b00;
    #1; chk("f c10 ifValid", 32'(bus.ifValid), 0);
        chk("f c10 addr", bus.imemReqAddr, 32'h400);

    // Branch redirect while waiting; late response must be dropped
    doReset();
    lat = 3;
    #1; tick();
    pcSel        = 2'b01;
    branchTarget = 32'h200;
    #1; chk("b c1 reqValid", 32'(bus.imemReqValid), 0);
    tick();
    pcSel = 2'b00;
    #1; chk("b c2 reqValid", 32'(bus.imemReqValid), 0);
    tick();
    #1; chk("b c3 reqValid", 32'(bus.imemReqValid), 0);
        chk("b c3 ifValid", 32'(bus.ifValid), 0);
    tick();
    lat = 1;
    #1; chk("b c4 ifValid", 32'(bus.ifValid), 0);
        chk("b c4 reqValid", 32'(bus.imemReqValid), 1);
        chk("b c4 addr", bus.imemReqAddr, 32'h200);
    tick();
    #1; tick();
    #1; chk("b c6 ifPc", bus.ifPc, 32'h200);
        chk("b c6 ifInstr", bus.ifInstr, 32'hA000_0200);

    // jalr redirect while memory is ready: no handshake, bit0 cleared
    doReset();
    pcSel      = 2'b10;
    jalrTarget = 32'h301;
    #1; chk("j c0 reqValid", 32'(bus.imemReqValid), 0);
    tick();
    pcSel = 2'b00;
    #1; chk("j c1 reqValid", 32'(bus.imemReqValid), 1);
        chk("j c1 addr", bus.imemReqAddr, 32'h300);
    tick();
    #1; tick();
    #1; chk("j c3 ifPc", bus.ifPc, 32'h300);
        chk("j c3 ifInstr", bus.ifInstr, 32'hA000_0300);

    // Trap redirect in the same cycle as the response
    doReset();
    #1; tick();
    pcSel = 2'b11;
    #1; tick();
    pcSel = 2'b00;
    #1; chk("t c2 ifValid", 32'(bus.ifValid), 0);
        chk("t c2 reqValid", 32'(bus.imemReqValid), 1);
        chk("t c2 addr", bus.imemReqAddr, 32'h100);

    // Reset asserted mid-WAIT with a valid IF/ID entry
    doReset();
    #1; tick();
    #1; tick();
    bus.idReady = 1'b0;
    lat         = 3;
    #1; chk("r c2 ifValid", 32'(bus.ifValid), 1);
    tick();
    rst_n = 1'b0;
    #1; chk("r c3 ifValid", 32'(bus.ifValid), 0);
        chk("r c3 ifPc", bus.ifPc, 32'h0);
        chk("r c3 ifInstr", bus.ifInstr, 32'h0000_0013);
        chk("r c3 reqValid", 32'(bus.imemReqValid), 0);
    tick();
    rst_n       = 1'b1;
    lat         = 1;
    bus.idReady = 1'b1;
    #1; chk("r c4 reqValid", 32'(bus.imemReqValid), 1);
        chk("r c4 addr", bus.imemReqAddr, 32'h0);
    tick();
    #1; tick();
    #1; chk("r c6 ifValid", 32'(bus.ifValid), 1);
        chk("r c6 ifPc", bus.ifPc, 32'h0);
        chk("r c6 ifInstr", bus.ifInstr, 32'hA000_0000);

    // Misaligned branch target
    doReset();
    pcSel        = 2'b01;
    branchTarget = 32'h202;
    #1; chk("m c0 reqValid", 32'(bus.imemReqValid), 0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("m c0 trap", 32'(misalignTrap), 0);
    tick();
    pcSel = 2'b00;
    #1; chk("m c1 trap", 32'(misalignTrap), 1);
        chk("m c1 addr", bus.imemReqAddr, 32'h100);
    tick();
    #1; chk("m c2 trap", 32'(misalignTrap), 0);
`else
    tick();
    pcSel = 2'b00;
    #1; chk("m c1 addr", bus.imemReqAddr, 32'h202);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
IF stage of the riscv 5-stage core. Holds the program counter and applies the 2-bit PC selection produced by the branch-resolution logic. Issues one instruction-memory request at a time over a valid/ready handshake. Delivers {pc, instruction} to the IF/ID boundary through a valid/ready output register, with flush on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, target for pcSel = 2'b11
ADDR_WIDTH, 32, PC/address width (instructions fixed 32-bit)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
pcSel  in  2  00 sequential, 01 jumpOrBranch, 10 jalr, 11 trap; non-zero = redirect this cycle
branchTarget  in  ADDR_WIDTH  target for 01
jalrTarget  in  ADDR_WIDTH  target for 10 (bit0 forced 0)
imemReqValid  out  1  fetch request valid
imemReqReady  in  1  memory accepts request
imemReqAddr  out  ADDR_WIDTH  fetch address (= pc)
imemRespValid  in  1  response valid, one cycle, cannot be back-pressured
imemRespData  in  32  instruction
ifValid  out  1  IF/ID register holds valid instruction
ifPc  out  ADDR_WIDTH  PC of held instruction
ifInstr  out  32  held instruction
idReady  in  1  ID consumes IF/ID contents this cycle when ifValid

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, ifValid=0, ifPc=0, ifInstr=32'h0000_0013 (NOP), imemReqValid=0 while in reset.
- redirect = (pcSel != 2'b00). Target: 01 branchTarget; 10 jalrTarget & ~1; 11 TRAP_VECTOR.
- imemReqValid = (state==REQ) && !redirect; imemReqAddr = pc (combinational from register).
- FSM states:
  - REQ: on handshake: reqPc<=pc, pc<=pc+4 (wraps mod 2^ADDR_WIDTH), go WAIT.
  - WAIT: on imemRespValid:
    - if !ifValid or idReady: load ifPc=reqPc, ifInstr=data, ifValid=1; go REQ.
    - else: capture into hold register; go HOLD.
  - HOLD: when idReady, move hold into IF/ID (ifValid stays 1); go REQ.
  - DROP: wait for imemRespValid, discard the data; go REQ.
- Output consumption: ifValid && idReady with no new load clears ifValid next cycle. ifValid/ifPc/ifInstr are stable while ifValid && !idReady.
- Redirect has priority over every other event in the same cycle:
  - pc <= target; ifValid <= 0 (flush).
  - REQ stays REQ; no request is issued that cycle.
  - WAIT: goes DROP. If imemRespValid arrives the same cycle, the data is discarded and the state goes REQ.
  - HOLD: hold buffer is discarded; goes REQ.
  - DROP: stays DROP; pc is updated.
- Throughput: at most one outstanding request; best case one instruction per 2 cycles with a 1-cycle memory.
- Latency: response cycle N gives ifValid=1 at N+1.

Optional Feature:
PC_MISALIGN_TRAP_EN
- Defined: adds output misalignTrap (1 bit, registered, reset 0). If a selected 01/10 target has bits[1:0] != 0, pc <= TRAP_VECTOR instead, and misalignTrap pulses high for 1 cycle. Flush and DROP rules are unchanged.
- Undefined: no port; the target is loaded as-is, with only the jalr bit0 clear.

Test Plan:
- Reset release, memory always ready, 1-cycle response, idReady=1 -> requests at 0x0,0x4,0x8; ifPc 0x0,0x4,0x8 with matching ifInstr; ifValid alternates 1/0.
- idReady=0 for 5 cycles with instruction at 0x4 held and response for 0x8 arriving -> state HOLD; ifPc stays 0x4; no new request; after idReady=1, ifPc=0x8 next cycle, then request 0xC.
- pcSel=01, branchTarget=0x200 while in WAIT; response arrives 2 cycles later -> response discarded; ifValid=0; next request address 0x200.
- pcSel=10, jalrTarget=0x301 in the same cycle as imemReqReady=1 -> no handshake that cycle; pc=0x300; next request 0x300.
- pcSel=11 in the same cycle as imemRespValid in WAIT -> data dropped; pc=0x100; state REQ; ifValid=0.
- rst_n asserted mid-WAIT, then released -> outputs at reset values immediately; first request 0x0; the stale response is ignored because the memory model is also reset. With PC_MISALIGN_TRAP_EN, pcSel=01 with target 0x202 -> pc=0x100; misalignTrap pulses once.
